// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle RV32M MUL/MULH/MULHSU/MULHU controller driving an external ripple-carry adder.
// Optional MUL_ZERO_SKIP_EN: a zero operand bypasses the shift-and-add loop and completes in one cycle.
module mul_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic            add_cin,
  input  logic [XLEN-1:0] add_sum,
  input  logic            add_cout
);

  localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ONE    = XLEN'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_NEG_LO,
    S_NEG_HI,
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic            neg_q;
  logic            carry_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] mcand;

  // Operand decode at acceptance: signedness, magnitudes and sign of the final product.
  logic            s1, s2;
  logic            rs1_neg, rs2_neg;
  logic            start_neg;
  logic [XLEN-1:0] m1, m2;

  always_comb begin
    s1        = (op == 2'b01) || (op == 2'b10);
    s2        = (op == 2'b01);
    rs1_neg   = s1 & rs1[XLEN-1];
    rs2_neg   = s2 & rs2[XLEN-1];
    m1        = rs1_neg ? (~rs1 + ONE) : rs1;
    m2        = rs2_neg ? (~rs2 + ONE) : rs2;
    start_neg = rs1_neg ^ rs2_neg;
  end

`ifdef MUL_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (rs1 == '0) || (rs2 == '0);
`endif

  // Shifted accumulator after one CALC iteration: {cout, sum, acc_lo[XLEN-1:1]}.
  logic [XLEN-1:0] calc_hi;
  logic [XLEN-1:0] calc_lo;

  assign calc_hi = {add_cout, add_sum[XLEN-1:1]};
  assign calc_lo = {add_sum[0], acc_lo[XLEN-1:1]};

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      S_CALC: begin
        add_a = acc_hi;
        add_b = acc_lo[0] ? mcand : '0;
      end
      S_NEG_LO: begin
        add_a   = ~acc_lo;
        add_cin = 1'b1;
      end
      S_NEG_HI: begin
        add_a   = ~acc_hi;
        add_cin = carry_q;
      end
      default: begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= 2'b00;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            neg_q  <= start_neg;
            acc_hi <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
`ifdef MUL_ZERO_SKIP_EN
            if (zero_op) begin
              acc_lo <= '0;
              mcand  <= '0;
              result <= '0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              acc_lo <= m1;
              mcand  <= m2;
              state  <= S_CALC;
            end
`else
            acc_lo <= m1;
            mcand  <= m2;
            state  <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          acc_hi <= calc_hi;
          acc_lo <= calc_lo;
          cnt    <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            if (neg_q) begin
              state <= S_NEG_LO;
            end else begin
              // Result is registered with the last accumulator update so it is valid alongside done.
              state  <= S_DONE;
              done   <= 1'b1;
              result <= (op_q == 2'b00) ? calc_lo : calc_hi;
            end
          end
        end
        S_NEG_LO: begin
          acc_lo  <= add_sum;
          carry_q <= add_cout;
          state   <= S_NEG_HI;
        end
        S_NEG_HI: begin
          acc_hi <= add_sum;
          state  <= S_DONE;
          done   <= 1'b1;
          result <= (op_q == 2'b00) ? acc_lo : add_sum;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed vector table, reset/abort sequence and random ops vs. a 64-bit product model.
module tb_mul_seq_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            busy, done, add_cin, add_cout;
  logic [XLEN-1:0] result, add_a, add_b, add_sum;

  int n_checks = 0;
  int n_fail   = 0;

  mul_seq_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Behavioural FA-chain adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{XLEN{1'b0}}, add_cin};

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    int          inj;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: sign/zero-extend to 64 bits and multiply; low 64 bits of the true product.
  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic        sa, sb;
    logic [63:0] a64, b64, p;
    sa  = (o == 2'b01) || (o == 2'b10);
    sb  = (o == 2'b01);
    a64 = sa ? {{32{a[31]}}, a} : {32'b0, a};
    b64 = sb ? {{32{b[31]}}, b} : {32'b0, b};
    p   = a64 * b64;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic neg;
`ifdef MUL_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 1;
`endif
    neg = (((o == 2'b01) || (o == 2'b10)) && a[31]) ^ ((o == 2'b01) && b[31]);
    return neg ? XLEN + 3 : XLEN + 1;
  endfunction

  // Called #1 after a clock edge; returns #1 after the edge that follows the DONE cycle (IDLE).
  // inj = cycle index after acceptance in which a stray start pulse is driven (must be ignored).
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int inj);
    int lat;
    int busy_cnt;
    logic [31:0] got;
    lat      = 0;
    busy_cnt = 0;
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      start = (k == inj);
      op    = 2'($urandom);
      rs1   = $urandom;
      rs2   = $urandom;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k + 1;
        break;
      end
    end
    got = result;
    chk({nm, " result"}, got, exp_res);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, " done_pulse"}, {30'b0, busy, done}, 32'b0);
    chk({nm, " result_held"}, result, exp_res);
    chk({nm, " adder_idle"}, {31'b0, |{add_a, add_b, add_cin}}, 32'b0);
    $display("%-14s op=%0d rs1=%h rs2=%h result=%h latency=%0d", nm, o, a, b, got, lat);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"mul_7x6",      2'b00, 32'h7,        32'h6,        32'h0000002A, 33, -1};
    vecs[1] = '{"mulh_m1x2",    2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 35, -1};
    vecs[2] = '{"mulhu_max",    2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32};
    vecs[3] = '{"mulhsu_min",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35, -1};
    vecs[4] = '{"mulh_min_sq",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 33, 10};
    vecs[5] = '{"mul_neg_lo",   2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 33, -1};
`ifdef MUL_ZERO_SKIP_EN
    vecs[6] = '{"mul_0x5",      2'b00, 32'h0,        32'h5,        32'h0,         1, 0};
`else
    vecs[6] = '{"mul_0x5",      2'b00, 32'h0,        32'h5,        32'h0,        33, -1};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy_done", {30'b0, busy, done}, 32'b0);
    chk("reset result", result, 32'b0);
    chk("reset adder", {31'b0, |{add_a, add_b, add_cin}}, 32'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].inj);

    // Abort in the middle of CALC with an asynchronous reset
    start = 1'b1;
    op    = 2'b00;
    rs1   = 32'h1234;
    rs2   = 32'h5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_abort busy", {31'b0, busy}, 32'b1);
    rst = 1'b1;
    #1;
    chk("abort busy_done", {30'b0, busy, done}, 32'b0);
    chk("abort result", result, 32'b0);
    chk("abort adder", {31'b0, |{add_a, add_b, add_cin}}, 32'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000000F, 33, -1);

    // Random operations against the model
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom);
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'h80000000;
        2: b = 32'h1;
        default: b = $urandom;
      endcase
      run_op("random", o, a, b, model_res(o, a, b), model_lat(o, a, b), $urandom_range(0, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle controller for RV32M MUL/MULH/MULHSU/MULHU.
- Sequences a shift-and-add multiply through one external XLEN-bit ripple-carry adder built from FA cells, exposed via the add_* ports.
- Sits beside the ALU in EX. Issue logic raises start and holds the pipeline while busy is high.

Parameters:
- XLEN, 32, operand/result width; the adder port width equals XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
- rs1  in  XLEN  multiplier operand
- rs2  in  XLEN  multiplicand operand
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- result  out  XLEN  product half selected by op; held until next accepted start
- add_a  out  XLEN  adder operand A
- add_b  out  XLEN  adder operand B
- add_cin  out  1  adder carry-in
- add_sum  in  XLEN  adder sum (combinational from add_a/add_b/add_cin)
- add_cout  in  1  adder carry-out

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, add_a=0, add_b=0, add_cin=0; all internal registers 0. Reset mid-operation aborts immediately. No partial result survives.
- States: IDLE, CALC, NEG_LO, NEG_HI, DONE.
- IDLE, start=1: latch op.
  - Signedness: s1 = (op==01 or op==10), s2 = (op==01).
  - Magnitudes are formed internally with local ~x+1: m1 = |rs1| if s1, else rs1; m2 likewise.
  - neg = (s1 & rs1[XLEN-1]) XOR (s2 & rs2[XLEN-1]).
  - acc_hi=0, acc_lo=m1, mcand=m2, cnt=0. Go to CALC.
- CALC: one iteration per cycle, XLEN cycles.
  - Drive add_a=acc_hi, add_b = acc_lo[0] ? mcand : 0, add_cin=0.
  - Register {acc_hi,acc_lo} <= {add_cout, add_sum, acc_lo[XLEN-1:1]}.
  - cnt increments. At cnt==XLEN-1, go to NEG_LO if neg, else DONE.
- NEG_LO: add_a=~acc_lo, add_b=0, add_cin=1. Register acc_lo<=add_sum, carry_q<=add_cout. Go to NEG_HI.
- NEG_HI: add_a=~acc_hi, add_b=0, add_cin=carry_q. Register acc_hi<=add_sum. Go to DONE.
- DONE: done=1 for this cycle only. result <= (op==00) ? acc_lo : acc_hi. Go to IDLE.
  - result becomes visible in the DONE cycle: registered together with the final accumulator update, or selected combinationally from acc while done=1. Either way it is held afterwards.
- Outside CALC/NEG_*: add_a, add_b, add_cin driven to 0.
- Latency, with start sampled at edge 0:
  - done high in the cycle after edge XLEN (no negation), i.e. XLEN+1 cycles from request.
  - XLEN+3 cycles with negation.
  - Back-to-back: a new start is accepted in the IDLE cycle directly after DONE.
- Start while busy (including the DONE cycle) is ignored: no latch, no queueing.
- Operand changes after acceptance have no effect.
- Magnitude of -2^(XLEN-1) is 2^(XLEN-1) as an unsigned value; no overflow special case.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined: in IDLE, if start=1 and (rs1==0 or rs2==0), clear acc_hi/acc_lo and go directly to DONE. done is then high in the cycle after acceptance (latency 1) with result=0, and the adder is not driven.
- Undefined: zero operands take the full CALC path with normal latency and result 0.

Test Plan:
- MUL rs1=7, rs2=6 → result=0x0000002A; done exactly 33 cycles after start; busy high 33 cycles.
- MULH rs1=0xFFFFFFFF, rs2=0x00000002 → result=0xFFFFFFFF; done at 35 cycles (negation path).
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → result=0xFFFFFFFE, 33 cycles.
- MULHSU rs1=0x80000000, rs2=0xFFFFFFFF → result=0x80000000, 35 cycles.
- MULH rs1=0x80000000, rs2=0x80000000 → 0x40000000. Then a start pulse mid-CALC is ignored; that operation's result is unchanged.
- Assert rst at cycle 10 of CALC → busy=0, done=0, result=0, add_* =0 immediately. Next MUL 3×5 gives 0x0000000F. With MUL_ZERO_SKIP_EN, MUL 0×5 gives done after 1 cycle, result=0.
